// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM state encoding and flag bit positions for the multi-cycle ALU.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_UDIV = 4'b0110;
  localparam logic [3:0] OP_SDIV = 4'b0111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the execute-stage controller and seq_alu.
interface seq_alu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Remainder;
  logic [3:0]       ALUFlags;

  modport master (
    output start, ALUControl, a, b,
    input  busy, done, Result, Remainder, ALUFlags
  );

  modport slave (
    input  start, ALUControl, a, b,
    output busy, done, Result, Remainder, ALUFlags
  );
endinterface

// File: rtl/seq_alu_iter_divider.sv
// Unsigned restoring divider: one quotient bit per step, WIDTH steps after load.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   trial;

  // Borrow in the top bit means the shifted partial remainder was below the divisor.
  always_comb trial = {remainder, quotient[WIDTH-1]} - {1'b0, dvs};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      dvs       <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dvs       <= divisor;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        remainder <= trial[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        remainder <= {remainder[WIDTH-2:0], quotient[WIDTH-1]};
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU: single-cycle logic ops, iterative multiply and divide.
// state | meaning
// IDLE  | accepting start; single-cycle ops and divide-by-zero complete here
// MUL   | one shift-add step per cycle, WIDTH steps
// DIV   | one restoring step on magnitudes per cycle, WIDTH steps
// FIX   | apply quotient/remainder signs, raise done
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit MUL_HIGH = 1'b0
) (
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mul_a;
  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_res;
  logic               neg_q;
  logic               neg_r;

  logic [WIDTH-1:0]   b_op;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   imm_res;
  logic               imm_c;
  logic               imm_v;
  logic               is_div;
  logic               is_sdiv;
  logic               b_zero;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               div_load;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  function automatic logic [3:0] mk_flags(logic [WIDTH-1:0] r, logic c, logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  always_comb begin
    b_op    = (bus.ALUControl == OP_SUB) ? ~bus.b : bus.b;
    sum     = {1'b0, bus.a} + {1'b0, b_op} + {{WIDTH{1'b0}}, bus.ALUControl == OP_SUB};
    imm_res = '0;
    imm_c   = 1'b0;
    imm_v   = 1'b0;
    case (bus.ALUControl)
      OP_ADD, OP_SUB: begin
        imm_res = sum[WIDTH-1:0];
        imm_c   = sum[WIDTH];
        imm_v   = (bus.a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  imm_res = bus.a & bus.b;
      OP_OR:   imm_res = bus.a | bus.b;
      default: imm_res = '0;
    endcase

    is_div   = (bus.ALUControl == OP_UDIV) || (bus.ALUControl == OP_SDIV);
    is_sdiv  = (bus.ALUControl == OP_SDIV);
    b_zero   = (bus.b == '0);
    a_mag    = (is_sdiv && bus.a[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.a) : bus.a;
    b_mag    = (is_sdiv && bus.b[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.b) : bus.b;
    div_load = (state == S_IDLE) && bus.start && is_div && !b_zero;

    // Add into the upper half, then shift the whole product right one place.
    mul_sum  = {1'b0, mul_acc[2*WIDTH-1:WIDTH]} + {1'b0, (mul_acc[0] ? mul_a : {WIDTH{1'b0}})};
    mul_next = {mul_sum, mul_acc[WIDTH-1:1]};
    mul_res  = MUL_HIGH ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
  end

  iter_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (state == S_DIV),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quot),
    .remainder (rem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      count         <= '0;
      mul_a         <= '0;
      mul_acc       <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.Result    <= '0;
      bus.Remainder <= '0;
      bus.ALUFlags  <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.ALUControl == OP_MUL) begin
              mul_a    <= bus.a;
              mul_acc  <= {{WIDTH{1'b0}}, bus.b};
              count    <= CW'(WIDTH);
              bus.busy <= 1'b1;
              state    <= S_MUL;
            end else if (is_div && !b_zero) begin
              neg_q    <= is_sdiv && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              neg_r    <= is_sdiv && bus.a[WIDTH-1];
              count    <= CW'(WIDTH);
              bus.busy <= 1'b1;
              state    <= S_DIV;
            end else if (is_div) begin
              bus.Result    <= '1;
              bus.Remainder <= bus.a;
              bus.ALUFlags  <= mk_flags('1, 1'b0, 1'b0);
              bus.done      <= 1'b1;
            end else begin
              bus.Result    <= imm_res;
              bus.Remainder <= '0;
              bus.ALUFlags  <= mk_flags(imm_res, imm_c, imm_v);
              bus.done      <= 1'b1;
            end
          end
        end
        S_MUL: begin
          mul_acc <= mul_next;
          count   <= count - CW'(1);
          if (count == CW'(1)) begin
            bus.Result    <= mul_res;
            bus.Remainder <= '0;
            bus.ALUFlags  <= mk_flags(mul_res, 1'b0, 1'b0);
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= S_IDLE;
          end
        end
        S_DIV: begin
          count <= count - CW'(1);
          if (count == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          bus.Result    <= neg_q ? ({WIDTH{1'b0}} - quot) : quot;
          bus.Remainder <= neg_r ? ({WIDTH{1'b0}} - rem) : rem;
          bus.ALUFlags  <= mk_flags(neg_q ? ({WIDTH{1'b0}} - quot) : quot, 1'b0, 1'b0);
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU.
- Add/sub/AND/OR complete in one registered cycle.
- Multiply and divide run on iterative shift-add / restoring-division engines, so no wide combinational multiplier or divider sits in the critical path.
- Sits in the execute stage of the multi-cycle core. The controller issues `start` and stalls on `busy` until `done`.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- MUL_HIGH, 0, when 1 the MUL op returns the upper WIDTH bits of the unsigned 2*WIDTH product instead of the lower.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  operation request; accepted only when busy=0.
- ALUControl  in  4  op code, sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- busy  out  1  high from the cycle after acceptance until the cycle done is asserted (inclusive of neither).
- done  out  1  one-cycle pulse; Result/Remainder/ALUFlags valid from this cycle.
- Result  out  WIDTH  registered result, held until the next done.
- Remainder  out  WIDTH  division remainder (sign follows dividend for SDIV), 0 for other ops.
- ALUFlags  out  4  {N,Z,C,V}, registered with Result.

Behaviour:
- Reset (asynchronous):
  - busy=0, done=0, Result=0, Remainder=0, ALUFlags=0; FSM→IDLE.
  - Reset mid-operation aborts the op; no done is issued.
- Op codes:
  - 000x: ADD (x=0) / SUB (x=1, A+~B+1).
  - 0010: AND. 0011: OR.
  - 0100: MUL.
  - 0110: UDIV. 0111: SDIV.
  - Any other code: Result=0, 1-cycle latency.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE:
    - start=1 with a 1-cycle op (or a divide by zero) → Result registered at that edge; done=1 next cycle; stay IDLE.
    - start=1 with MUL → MUL; with UDIV/SDIV → DIV. Iteration counter loaded with WIDTH.
  - MUL: one shift-add step per cycle. After WIDTH steps → done; back to IDLE.
    - Latency start→done = WIDTH+1 cycles.
  - DIV: one restoring step on magnitudes per cycle. After WIDTH steps → FIX.
  - FIX: apply signs (quotient negated if sign(a)^sign(b) for SDIV; remainder takes sign of a) → done; IDLE.
    - Latency start→done = WIDTH+2 cycles. UDIV also passes through FIX (no negation) so latency is identical.
- start while busy=1 is ignored; no queueing. start in the same cycle as done is accepted (done cycle is IDLE).
- Width rules:
  - ADD/SUB use a WIDTH+1 sum.
  - MUL keeps a 2*WIDTH accumulator; the MUL_HIGH selection happens at completion.
- Divide by zero (b==0), detected at acceptance, 1-cycle latency:
  - Result = all ones.
  - Remainder = a.
- SDIV overflow (a = most-negative, b = −1): Result = a, Remainder = 0. Falls out of magnitude arithmetic; must be verified.
- Flags:
  - N = Result[WIDTH-1]; Z = (Result==0) for every op.
  - C = carry out of the WIDTH+1 sum, ADD/SUB only, else 0.
  - V = signed overflow, ADD/SUB only, else 0.
- Operand registers are captured at acceptance. Changes on a/b/ALUControl while busy have no effect.

Decomposition:
- Package seq_alu_pkg:
  - Op-code localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_UDIV, OP_SDIV).
  - FSM state encoding.
  - Flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One natural sub-module, iter_divider:
  - WIDTH-parameterised unsigned restoring divider.
  - Ports: load / step / quotient / remainder.
  - Owned by the DIV state; the sign handling (FIX) stays in seq_alu.
- Multiplier stays inline; it is a shift register plus adder.

Test Plan (WIDTH=32):
- ADD overflow: start, ALUControl=0000, a=0x7FFFFFFF, b=1 → done 1 cycle later, Result=0x80000000, ALUFlags=1001.
- SUB equal: ALUControl=0001, a=b=5 → Result=0, ALUFlags=0110 (Z, C set).
- MUL: ALUControl=0100, a=0x00010000, b=0x00010001 → done exactly 33 cycles after start, Result=0x00010000 (MUL_HIGH=0). With MUL_HIGH=1 → Result=0x00000001.
- SDIV: ALUControl=0111, a=−7 (0xFFFFFFF9), b=2 → done at 34 cycles, Result=0xFFFFFFFD (−3), Remainder=0xFFFFFFFF (−1), N=1.
  - Repeat with a=0x80000000, b=0xFFFFFFFF → Result=0x80000000, Remainder=0.
- Divide by zero and ignored start: UDIV a=9, b=0 → done after 1 cycle, Result=0xFFFFFFFF, Remainder=9.
  - Then start UDIV 100/7. Pulse start with ADD during busy → ignored; done at 34 cycles with Result=14, Remainder=2.
- Reset mid-op: assert reset 10 cycles into a DIV → all outputs 0 immediately (async), no done afterward; a following ADD 2+3 completes normally with Result=5.
